flocra_axil_master: RTL

- AXI4-Lite initiator that drives the s0_axi slave port of the flocra core in the Verilator top-level model and in hardware bring-up benches.
- Accepts single read/write commands on a valid/ready command channel, runs one AXI4-Lite transaction at a time, and returns data and status on a valid/ready response channel.
- It is the master-side counterpart of the flocra register/memory slave interface.

---
 rtl/flocra_axil_pkg.sv | 32 +++
 rtl/flocra_axil_master_if.sv | 56 +++++
 rtl/flocra_axil_master.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/flocra_axil_pkg.sv
// Shared types and constants for the flocra AXI4-Lite initiator.
// Holds the FSM state enum, AXI response codes and the latched command payload.
package flocra_axil_pkg;

    // Widest address / data the latched command can hold.
    localparam int unsigned AXIL_ADDR_W = 32;
    localparam int unsigned AXIL_DATA_W = 32;
    localparam int unsigned AXIL_STRB_W = AXIL_DATA_W / 8;

    // Width of the per-handshake timeout counter.
    localparam int unsigned TMO_CNT_W = 16;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_B,
        RD_A,
        RD_R,
        RSP
    } axil_state_t;

    typedef struct packed {
        logic                   we;
        logic [AXIL_ADDR_W-1:0] addr;
        logic [AXIL_DATA_W-1:0] wdata;
        logic [AXIL_STRB_W-1:0] wstrb;
    } axil_cmd_t;

endpackage

// File: rtl/flocra_axil_master_if.sv
// AXI4-Lite bus between the flocra initiator and the s0_axi slave port.
// master modport: drives AW/W/AR channels and bready/rready.
// slave modport:  drives the ready signals and the B/R channels.
interface flocra_axil_master_if #(
    parameter int unsigned ADDR_WIDTH = 19,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );

endinterface

// File: rtl/flocra_axil_master.sv
// AXI4-Lite initiator for the flocra s0_axi slave port.
// Takes one read/write command on a valid/ready channel, runs a single AXI4-Lite
// transaction and returns data/status on a valid/ready response channel.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   cmd_*                  command channel (valid/ready, we, addr, wdata, wstrb)
//   rsp_*                  response channel (valid/ready, rdata, resp, timeout flag)
//   timeout_sticky_o       set by any timeout, cleared only by rst
//   m_axi                  AXI4-Lite master bus
module flocra_axil_master
    import flocra_axil_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 19,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 1023
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic                      cmd_we_i,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr_i,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb_i,

    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [DATA_WIDTH-1:0]     rsp_rdata_o,
    output logic [1:0]                rsp_resp_o,
    output logic                      rsp_timeout_o,
    output logic                      timeout_sticky_o,

    flocra_axil_master_if.master      m_axi
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic        TMO_EN     = (TIMEOUT != 0);
    // Counter value in the last allowed cycle of a handshake wait.
    localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT - 1);

    axil_state_t           state_q, state_d;
    axil_cmd_t             cmd_q, cmd_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic                  sticky_q, sticky_d;
    logic [TMO_CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic                  busy;
    logic                  aw_done;
    logic                  w_done;

    // Next-state and output logic.
    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        cmd_ready_d   = cmd_ready_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        sticky_d      = sticky_q;
        tmo_cnt_d     = tmo_cnt_q;
        busy          = 1'b0;
        // A channel is done once its valid is low or is being accepted this cycle.
        aw_done       = !awvalid_q || m_axi.awready;
        w_done        = !wvalid_q || m_axi.wready;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    cmd_d.we    = cmd_we_i;
                    cmd_d.addr  = AXIL_ADDR_W'(cmd_addr_i);
                    cmd_d.wdata = AXIL_DATA_W'(cmd_wdata_i);
                    cmd_d.wstrb = AXIL_STRB_W'(cmd_wstrb_i);
                    cmd_ready_d = 1'b0;
                    if (cmd_we_i) begin
                        state_d   = WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD_A;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR: begin
                busy = 1'b1;
                if (awvalid_q && m_axi.awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axi.wready)   wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    state_d  = WR_B;
                    bready_d = 1'b1;
                end
            end
            WR_B: begin
                busy = 1'b1;
                if (m_axi.bvalid) begin
                    state_d       = RSP;
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = m_axi.bresp;
                    rsp_timeout_d = 1'b0;
                end
            end
            RD_A: begin
                busy = 1'b1;
                if (m_axi.arready) begin
                    state_d   = RD_R;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            RD_R: begin
                busy = 1'b1;
                if (m_axi.rvalid) begin
                    state_d       = RSP;
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = m_axi.rdata;
                    rsp_resp_d    = m_axi.rresp;
                    rsp_timeout_d = 1'b0;
                end
            end
            RSP: begin
                if (rsp_ready_i) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort when the counter would reach TIMEOUT on this edge; the abort
        // wins over any handshake landing on the same edge.
        if (TMO_EN && busy && (tmo_cnt_q == TMO_LAST)) begin
            state_d       = RSP;
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            bready_d      = 1'b0;
            arvalid_d     = 1'b0;
            rready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = '0;
            rsp_resp_d    = RESP_SLVERR;
            rsp_timeout_d = 1'b1;
            sticky_d      = 1'b1;
        end

        // Counter restarts on every state change and only runs while waiting on the bus.
        if (state_d != state_q) begin
            tmo_cnt_d = '0;
        end else if (busy) begin
            tmo_cnt_d = tmo_cnt_q + TMO_CNT_W'(1);
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cmd_q         <= '0;
            cmd_ready_q   <= 1'b1;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= RESP_OKAY;
            rsp_timeout_q <= 1'b0;
            sticky_q      <= 1'b0;
            tmo_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            cmd_ready_q   <= cmd_ready_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
            sticky_q      <= sticky_d;
            tmo_cnt_q     <= tmo_cnt_d;
        end
    end

    // Direction is consumed at acceptance; the latched copy is for debug visibility.
    logic unused_we;
    assign unused_we = cmd_q.we;

    assign cmd_ready_o      = cmd_ready_q;
    assign rsp_valid_o      = rsp_valid_q;
    assign rsp_rdata_o      = rsp_rdata_q;
    assign rsp_resp_o       = rsp_resp_q;
    assign rsp_timeout_o    = rsp_timeout_q;
    assign timeout_sticky_o = sticky_q;

    assign m_axi.awaddr  = ADDR_WIDTH'(cmd_q.addr);
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = DATA_WIDTH'(cmd_q.wdata);
    assign m_axi.wstrb   = STRB_WIDTH'(cmd_q.wstrb);
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;
    assign m_axi.araddr  = ADDR_WIDTH'(cmd_q.addr);
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;

endmodule
